// File: rtl/reg_ld_clr_inc_tc.sv
// Up-counting register with load, synchronous clear, programmable terminal count,
// wrap/saturate limit behaviour, sticky overflow and a load/increment conflict flag.
module reg_ld_clr_inc_tc #(
    parameter int width = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    input  logic [width-1:0] limit,
    input  logic             ld,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] dout,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             err
);

    localparam logic [width-1:0] ALL_ONES = {width{1'b1}};
    localparam logic [width-1:0] ZERO     = {width{1'b0}};
    localparam logic [width-1:0] ONE      = width'(1);

    logic [width-1:0] dout_q, dout_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q,  ovf_d;
    logic             err_q,  err_d;
    logic             at_bound_s;

    // Reaching the limit or the top of the count range is the boundary; the
    // all-ones case only occurs after loading a value above the limit.
    assign at_bound_s = (dout_q == limit) || (dout_q == ALL_ONES);

    // Next-state selection, in priority order clr > conflict > load > increment.
    always_comb begin
        dout_d = dout_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        err_d  = 1'b0;
        if (clr) begin
            dout_d = ZERO;
            ovf_d  = 1'b0;
        end else if (ld && inc) begin
            err_d = 1'b1;
        end else if (ld) begin
            dout_d = din;
            ovf_d  = 1'b0;
        end else if (inc) begin
            if (at_bound_s) begin
                ovf_d = 1'b1;
                if (SAT) begin
                    dout_d = dout_q;
                end else begin
                    dout_d = ZERO;
                    wrap_d = 1'b1;
                end
            end else begin
                dout_d = dout_q + ONE;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= ZERO;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    assign dout = dout_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign err  = err_q;
    assign tc   = (dout_q == limit);

endmodule

// File: tb/tb_reg_ld_clr_inc_tc.sv
// Directed bench for reg_ld_clr_inc_tc: a wrapping (SAT=0) and a saturating
// (SAT=1) 4-bit instance, each driven through its own step sequence.
module tb_reg_ld_clr_inc_tc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_ld, a_clr, a_inc;
    logic [3:0] a_din, a_limit, a_dout;
    logic       a_tc, a_wrap, a_ovf, a_err;

    logic       b_rst, b_ld, b_clr, b_inc;
    logic [3:0] b_din, b_limit, b_dout;
    logic       b_tc, b_wrap, b_ovf, b_err;

    int n_checks = 0;
    int n_errors = 0;

    reg_ld_clr_inc_tc #(.width(4), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(a_rst), .din(a_din), .limit(a_limit), .ld(a_ld), .clr(a_clr),
        .inc(a_inc), .dout(a_dout), .tc(a_tc), .wrap(a_wrap), .ovf(a_ovf), .err(a_err)
    );

    reg_ld_clr_inc_tc #(.width(4), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(b_rst), .din(b_din), .limit(b_limit), .ld(b_ld), .clr(b_clr),
        .inc(b_inc), .dout(b_dout), .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf), .err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge pass, sample 1 time unit later.
    task automatic step_a(input logic rst, input logic clr, input logic ld, input logic inc,
                          input logic [3:0] din, input logic [3:0] limit);
        a_rst = rst; a_clr = clr; a_ld = ld; a_inc = inc; a_din = din; a_limit = limit;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic rst, input logic clr, input logic ld, input logic inc,
                          input logic [3:0] din, input logic [3:0] limit);
        b_rst = rst; b_clr = clr; b_ld = ld; b_inc = inc; b_din = din; b_limit = limit;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] d, input logic w,
                         input logic o, input logic e);
        chk({tag, ".dout"}, a_dout, d);
        chk({tag, ".wrap"}, a_wrap, w);
        chk({tag, ".ovf"},  a_ovf,  o);
        chk({tag, ".err"},  a_err,  e);
    endtask

    initial begin
        b_rst = 1'b1; b_clr = 1'b0; b_ld = 1'b0; b_inc = 1'b0; b_din = 4'h0; b_limit = 4'h0;
        a_rst = 1'b0; a_clr = 1'b0; a_ld = 1'b0; a_inc = 1'b0; a_din = 4'h0; a_limit = 4'h0;
        #2;

        // Reset wins over a concurrent load.
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 4'h5);
        chk_a("reset", 4'h0, 1'b0, 1'b0, 1'b0);

        // Wrap count toward limit 5.
        for (int i = 1; i <= 6; i++) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h5);
            chk_a($sformatf("wrapcnt%0d", i), (i == 6) ? 4'h0 : 4'(i),
                  (i == 6), (i == 6), 1'b0);
            chk($sformatf("wrapcnt%0d.tc", i), a_tc, (i == 5));
        end
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h5);
        chk_a("idle", 4'h0, 1'b0, 1'b1, 1'b0);

        // Count to 7 with a high limit; ovf stays sticky.
        for (int i = 1; i <= 7; i++) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF);
        end
        chk_a("count7", 4'h7, 1'b0, 1'b1, 1'b0);

        // Conflict: hold, one-cycle err, ovf unchanged; then plain load.
        step_a(1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 4'hF);
        chk_a("conflict", 4'h7, 1'b0, 1'b1, 1'b1);
        step_a(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 4'hF);
        chk_a("load2", 4'h2, 1'b0, 1'b0, 1'b0);

        // Load above limit, then climb through all-ones.
        step_a(1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 4'h3);
        chk_a("loadE", 4'hE, 1'b0, 1'b0, 1'b0);
        chk("loadE.tc", a_tc, 1'b0);
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h3);
        chk_a("incF", 4'hF, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h3);
        chk_a("incwrapF", 4'h0, 1'b1, 1'b1, 1'b0);
        step_a(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h3);
        chk_a("clrinc", 4'h0, 1'b0, 1'b0, 1'b0);

        // Clear outranks load.
        step_a(1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'h3);
        chk_a("clrld", 4'h0, 1'b0, 1'b0, 1'b0);

        // limit=0: every inc from 0 wraps.
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        chk_a("lim0a", 4'h0, 1'b1, 1'b1, 1'b0);
        chk("lim0a.tc", a_tc, 1'b1);
        step_a(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        chk_a("lim0b", 4'h0, 1'b1, 1'b1, 1'b0);

        // Mid-sequence reset with other requests active.
        step_a(1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 4'h0);
        chk_a("preRst", 4'h0, 1'b0, 1'b1, 1'b1);
        step_a(1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 4'h0);
        chk_a("midRst", 4'h0, 1'b0, 1'b0, 1'b0);

        // Saturating instance.
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h3);
        chk("sat.rst.dout", b_dout, 4'h0);
        for (int i = 1; i <= 5; i++) begin
            step_b(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h3);
            chk($sformatf("sat%0d.dout", i), b_dout, (i >= 3) ? 4'h3 : 4'(i));
            chk($sformatf("sat%0d.ovf", i),  b_ovf,  (i >= 4));
            chk($sformatf("sat%0d.wrap", i), b_wrap, 1'b0);
            chk($sformatf("sat%0d.tc", i),   b_tc,   (i >= 3));
        end
        step_b(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h3);
        chk("satF.ovf", b_ovf, 1'b0);
        step_b(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h3);
        chk("satFinc.dout", b_dout, 4'hF);
        chk("satFinc.ovf",  b_ovf,  1'b1);
        chk("satFinc.wrap", b_wrap, 1'b0);
        chk("satFinc.err",  b_err,  1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
